// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch over req/ack memory plus IF/ID pipeline register
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [15:0] imm16_o,
    output logic        ext_select_o
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        load;
    logic [31:0] load_instr;
    logic [31:0] load_pc4;

    assign redir_tgt = redirect_pc_i & ~32'd3;
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        load         = 1'b0;
        load_instr   = imem_data_i;
        load_pc4     = pc_plus4;
        imem_req_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        pc_d = redir_tgt;
                    end else begin
                        pc_d = pc_plus4;
                        if (!flush_i) begin
                            if (stall_i) begin
                                skid_instr_d = imem_data_i;
                                skid_pc4_d   = pc_plus4;
                                state_d      = S_HOLD;
                            end else begin
                                load = 1'b1;
                            end
                        end
                    end
                end else if (redirect_i) begin
                    tgt_d   = redir_tgt;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                // pc already points past the parked word, so no request here
                if (redirect_i) begin
                    pc_d    = redir_tgt;
                    state_d = S_FETCH;
                end else if (flush_i) begin
                    state_d = S_FETCH;
                end else if (!stall_i) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc4   = skid_pc4_q;
                    state_d    = S_FETCH;
                end
            end
            S_DROP: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    tgt_d = redir_tgt;
                end
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? redir_tgt : tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = 32'd0;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load) begin
                instr_d = load_instr;
                pc4_d   = load_pc4;
                valid_d = 1'b1;
            end else begin
                instr_d = 32'd0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC & ~32'd3;
            tgt_q        <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
            instr_q      <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign instr_o      = instr_q;
    assign pc_plus4_o   = pc4_q;
    assign valid_o      = valid_q;
    assign imm16_o      = instr_q[15:0];
    // andi/ori/xori/lui share opcode prefix 4'b0011 and are zero-extended
    assign ext_select_o = (instr_q[31:28] != 4'b0011 || instr_q[27:26] > 2'b11) ? 1'b1 : 1'b0;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the simple CPU, directly upstream of decode and the immediate extender. Holds the PC and fetches over a variable-latency req/ack instruction-memory port. Registers the fetched word with stall, flush and redirect control. Decodes the 16-bit immediate and the sign/zero-extend select consumed by the extender.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals the PC register.
- imem_ack_i  in  1  memory has returned data; may assert in the same cycle as the request.
- imem_data_i  in  32  instruction word; valid only while imem_ack_i=1.
- stall_i  in  1  hazard unit: hold the IF/ID register.
- flush_i  in  1  invalidate the IF/ID register.
- redirect_i  in  1  load the PC from redirect_pc_i (branch/jump).
- redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0.
- instr_o  out  32  IF/ID instruction; 0 (nop) when invalid.
- pc_plus4_o  out  32  IF/ID PC+4 of instr_o.
- valid_o  out  1  instr_o holds a real instruction.
- imm16_o  out  16  instr_o[15:0], combinational.
- ext_select_o  out  1  combinational from instr_o[31:26]: 0 (zero-extend) for andi 6'h0C, ori 6'h0D, xori 6'h0E, lui 6'h0F; 1 (sign-extend) otherwise.

## Operation
- States:
  - FETCH: request outstanding.
  - HOLD: fetched word parked in a one-entry skid buffer while stalled.
  - DROP: waiting for an in-flight ack whose data must be discarded.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - On ack without stall: IF/ID takes the word, pc_plus4_o=pc+4, valid_o=1, pc<=pc+4.
  - On ack with stall: word and pc+4 go to the skid buffer, pc<=pc+4, go to HOLD.
  - No ack: stay in FETCH.
- HOLD:
  - imem_req_o=0.
  - When stall_i=0, IF/ID takes the skid entry, go to FETCH.
- Request protocol: once imem_req_o rises, imem_addr_o stays stable until the ack cycle.
- redirect_i (priority over every fetch result):
  - In FETCH with ack this cycle: discard the data, pc<=target, stay in FETCH.
  - In FETCH without ack: latch the target, go to DROP.
  - In HOLD: discard the skid entry, pc<=target, go to FETCH.
  - In DROP: update the latched target.
- DROP:
  - imem_req_o=1 with the old address.
  - On ack: discard the data, pc<=latched target, go to FETCH.
- IF/ID register priority: flush_i, then stall_i, then a new load.
  - Flush: instr_o=0, valid_o=0, pc_plus4_o unchanged.
  - Stall without flush: all IF/ID outputs hold.
  - No fetch result and no stall: valid_o<=0, instr_o<=0 (bubble).
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: pc=RESET_PC, state FETCH, instr_o=0, pc_plus4_o=0, valid_o=0, imm16_o=0, ext_select_o=1. imem_req_o=1 in the first cycle after reset release.
- Latency: ack at edge N puts the word on instr_o after edge N (one cycle). Zero-wait memory sustains one instruction per cycle.
- Reset asserted mid-request or in HOLD/DROP: all state clears immediately; any late ack is ignored until the new FETCH.
- Simultaneous events:
  - redirect with stall: the PC still redirects, and the IF/ID register holds.
  - flush with ack, no redirect: the IF/ID register clears and the acked word is dropped; pc still advances.

## Test plan
- Reset release, zero-wait memory returning 32'h3401_0005 (ori) at 0x0: next cycle instr_o=32'h3401_0005, pc_plus4_o=4, valid_o=1, imm16_o=16'h0005, ext_select_o=0. Next address is 4.
- Stall high 2 cycles while an ack for 0x8 arrives: IF/ID holds, imem_req_o=0 in HOLD. The stall drop loads the word for 0x8, and the next fetch address is 0xC.
- Memory with 3-cycle ack latency; redirect to 0x40 in cycle 1 of the wait: address stays 0x4 until ack, the data is discarded, the next request is 0x40, and valid_o=0 meanwhile.
- flush_i with ack of addi 32'h2002_FFFF: instr_o=0, valid_o=0. The following fetch is pc+4, and a later addi yields ext_select_o=1.
- redirect_pc_i=32'h0000_0013: fetch address 32'h0000_0010. With pc=32'hFFFF_FFFC, the next fetch is 0.
- Async reset pulse mid-DROP: outputs go to reset values without a clock edge, and fetch resumes at RESET_PC.
